// File: rtl/dw_weight_fetch.sv
// Weight-SRAM read sequencer for the depthwise kernel buffer: one KSIZE*KSIZE word
// kernel per block request. Optional macro DWF_PREFETCH_EN adds a one-entry pending blk_req.
module dw_weight_fetch #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int CW     = 10,
  parameter int KSIZE  = 3,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dw_comp,
  input  logic          start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [CW-1:0] i_ch_num,
  input  logic          blk_req,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          blkend,
  output logic          busy,
  output logic          done,
  output logic [2:0]    o_dbg_state
);
  localparam int KWORDS = KSIZE * KSIZE;
  localparam int WCW    = $clog2(KWORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_FETCH    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state, w_next;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_remain;
  logic [WCW-1:0]    r_wcnt;
  logic [RD_LAT-1:0] r_vld_pipe, r_last_pipe;
  logic [DW-1:0]     r_rdata;
  logic              r_rvalid, r_blkend;
  logic              w_issue, w_last_issue, w_drain_exit, w_pend;

  // Handshake: mem_ren is the read strobe; rvalid/blkend are single-cycle
  // qualifiers on rdata with no backpressure; blk_req and start are pulses.
  assign w_issue      = (r_state == S_FETCH) && dw_comp;
  assign w_last_issue = w_issue && (r_wcnt == WCW'(KWORDS - 1));
  assign w_drain_exit = (r_state == S_DRAIN) && r_blkend;

`ifdef DWF_PREFETCH_EN
  logic r_pend;
  assign w_pend = r_pend | blk_req;

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_pend <= 1'b0;
    end else if (w_drain_exit && r_remain != CW'(1) && w_pend) begin
      r_pend <= 1'b0;
    end else if ((r_state == S_FETCH || r_state == S_DRAIN) && blk_req) begin
      r_pend <= 1'b1;
    end
  end
`else
  assign w_pend = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (i_ch_num == '0) ? S_DONE : S_WAIT_REQ;
      S_WAIT_REQ: if (blk_req) w_next = S_FETCH;
      S_FETCH:    if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: begin
        if (r_blkend) begin
          if (r_remain == CW'(1)) w_next = S_DONE;
          else if (w_pend)        w_next = S_FETCH;
          else                    w_next = S_WAIT_REQ;
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Word counter idles at zero so every entry into FETCH starts a fresh kernel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr   <= i_base_addr;
        r_remain <= i_ch_num;
      end else begin
        if (w_issue)      r_addr   <= r_addr + AW'(1);
        if (w_drain_exit) r_remain <= r_remain - CW'(1);
      end
      if (r_state != S_FETCH) r_wcnt <= '0;
      else if (w_issue)       r_wcnt <= r_wcnt + WCW'(1);
    end
  end

  // Tags travel alongside the SRAM access so data is captured exactly when valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_blkend    <= 1'b0;
    end else begin
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      r_rvalid <= r_vld_pipe[RD_LAT-1];
      r_blkend <= r_vld_pipe[RD_LAT-1] & r_last_pipe[RD_LAT-1];
      if (r_vld_pipe[RD_LAT-1]) r_rdata <= mem_rdata;
    end
  end

  assign mem_ren     = w_issue;
  assign mem_raddr   = r_addr;
  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign blkend      = r_blkend;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dw_weight_fetch.sv
// Bench for dw_weight_fetch: layer vector table plus hand-written corner sequences,
// with an issue/return scoreboard against a 1-cycle SRAM model.
module tb_dw_weight_fetch;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_FETCH = 3'd2,
                         ST_DRAIN = 3'd3, ST_DONE = 3'd4;

  logic        clk, rst, dw_comp, start, blk_req;
  logic [15:0] i_base_addr;
  logic [9:0]  i_ch_num;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic [31:0] mem_rdata, rdata;
  logic        rvalid, blkend, busy, done;
  logic [2:0]  o_dbg_state;

  dw_weight_fetch dut (
    .clk(clk), .rst(rst), .dw_comp(dw_comp), .start(start),
    .i_base_addr(i_base_addr), .i_ch_num(i_ch_num), .blk_req(blk_req),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .rdata(rdata), .rvalid(rvalid), .blkend(blkend), .busy(busy),
    .done(done), .o_dbg_state(o_dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, a + 16'h1357};
  endfunction

  always @(posedge clk) if (mem_ren) mem_rdata <= mem_word(mem_raddr);

  int n_checks = 0, n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // scoreboard state: entry = {due cycle, last flag, data}
  logic [64:0] exp_q[$];
  logic [15:0] exp_addr;
  int exp_w, issues, beats, nblk, ndone, gap, cyc;
  int first_blk_cyc, issue10_cyc, last_beat_cyc, done_cyc;
  bit mon_en = 1'b0;

  task automatic reset_sb(input logic [15:0] base);
    exp_q.delete();
    exp_addr = base; exp_w = 0; issues = 0; beats = 0; nblk = 0; ndone = 0; gap = 0;
    first_blk_cyc = -1; issue10_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    cyc++;
    if (mon_en) begin
      if (mem_ren) begin
        check("raddr", mem_raddr, exp_addr);
        exp_q.push_back({cyc + 32'd2, (exp_w == 8), mem_word(exp_addr)});
        exp_addr = exp_addr + 16'd1;
        exp_w = (exp_w == 8) ? 0 : exp_w + 1;
        issues++;
        if (issues == 10) issue10_cyc = cyc;
      end else if (o_dbg_state == ST_FETCH) begin
        gap++;
        check("hold_addr", mem_raddr, exp_addr);
      end
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", beats, -1);
        end else begin
          e = exp_q.pop_front();
          check("rdata", rdata, e[31:0]);
          check("blkend", blkend, e[32]);
          check("latency", cyc, e[64:33]);
        end
        beats++;
        last_beat_cyc = cyc;
        if (blkend) begin
          nblk++;
          if (first_blk_cyc < 0) first_blk_cyc = cyc;
        end
      end else begin
        check("blkend_idle", blkend, 0);
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [9:0] n);
    i_base_addr = b; i_ch_num = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_layer(input logic [15:0] base, input logic [9:0] ch, input int stall_at,
                           input int stall_len, input int exp_beats, input logic [15:0] exp_end);
    int t = 0, stall_left = 0;
    bit stalled = 1'b0;
    reset_sb(base);
    do_start(base, ch);
    while (ndone == 0 && t < 2000) begin
      blk_req = 1'b0; dw_comp = 1'b1;
      if (stall_left > 0) begin
        dw_comp = 1'b0; stall_left--;
      end else if (!stalled && stall_at > 0 && issues == stall_at) begin
        stalled = 1'b1; dw_comp = 1'b0; stall_left = stall_len - 1;
      end
      if (o_dbg_state == ST_WAIT) blk_req = 1'b1;
      tick();
      t++;
    end
    blk_req = 1'b0; dw_comp = 1'b1;
    check("layer_timeout", (t < 2000), 1);
    repeat (3) tick();
    check("beats", beats, exp_beats);
    check("blkend_count", nblk, ch);
    check("end_addr", exp_addr, exp_end);
    check("queue_empty", exp_q.size(), 0);
    check("ren_gap", gap, stall_len);
    check("done_count", ndone, 1);
    check("done_after_last", done_cyc, last_beat_cyc + 1);
    check("idle_state", o_dbg_state, ST_IDLE);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [9:0]  ch;
    int          stall_at;
    int          stall_len;
    int          exp_beats;
    logic [15:0] exp_end;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] rb;
    int t;
    bit pre_sent;
    int kreq;

    rb = 16'($urandom_range(0, 65535));
    vecs[0] = '{16'h0100, 10'd2, 0, 0, 18, 16'h0112};
    vecs[1] = '{16'h0100, 10'd2, 4, 3, 18, 16'h0112};
    vecs[2] = '{16'hFFFE, 10'd1, 0, 0, 9, 16'h0007};
    vecs[3] = '{rb, 10'd3, 0, 0, 27, rb + 16'd27};
    vecs[4] = '{16'h0A00, 10'd1, $urandom_range(1, 8), $urandom_range(1, 4), 9, 16'h0A09};

    rst = 1'b1; dw_comp = 1'b1; start = 1'b0; blk_req = 1'b0;
    i_base_addr = '0; i_ch_num = '0;
    cyc = 0;
    reset_sb(16'h0);
    repeat (3) tick();
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_blkend", blkend, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 5; i++)
      run_layer(vecs[i].base, vecs[i].ch, vecs[i].stall_at, vecs[i].stall_len,
                vecs[i].exp_beats, vecs[i].exp_end);

    // zero channels goes straight to DONE
    reset_sb(16'h0050);
    do_start(16'h0050, 10'd0);
    check("ch0_done", done, 1);
    check("ch0_busy", busy, 1);
    tick();
    check("ch0_done_pulse", done, 0);
    check("ch0_idle", busy, 0);
    repeat (3) tick();
    check("ch0_no_ren", issues, 0);

    // reset in the middle of FETCH
    reset_sb(16'h0200);
    do_start(16'h0200, 10'd1);
    t = 0;
    while (issues < 5 && t < 50) begin
      blk_req = (o_dbg_state == ST_WAIT);
      tick();
      t++;
    end
    blk_req = 1'b0;
    check("midrst_reach5", (issues >= 5), 1);
    rst = 1'b1;
    tick();
    check("midrst_ren", mem_ren, 0);
    check("midrst_raddr", mem_raddr, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", o_dbg_state, ST_IDLE);
    rst = 1'b0;
    mon_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_rvalid", rvalid, 0);
    end
    tick();
    mon_en = 1'b1;
    run_layer(16'h0300, 10'd1, 0, 0, 9, 16'h0309);

    // blk_req arriving during FETCH of kernel 0
    reset_sb(16'h0400);
    do_start(16'h0400, 10'd2);
    pre_sent = 1'b0; kreq = 0; t = 0;
    while (ndone == 0 && t < 60) begin
      blk_req = 1'b0;
      if (o_dbg_state == ST_WAIT && kreq < 1) begin
        blk_req = 1'b1; kreq++;
      end else if (o_dbg_state == ST_FETCH && issues == 3 && !pre_sent) begin
        blk_req = 1'b1; pre_sent = 1'b1;
      end
      tick();
      t++;
    end
    blk_req = 1'b0;
`ifdef DWF_PREFETCH_EN
    check("pf_done", ndone, 1);
    check("pf_back_to_back", issue10_cyc, first_blk_cyc + 1);
    check("pf_beats", beats, 18);
    check("pf_blkends", nblk, 2);
`else
    check("nopf_stalled_issues", issues, 9);
    check("nopf_wait_state", o_dbg_state, ST_WAIT);
    check("nopf_no_done", ndone, 0);
    blk_req = 1'b1;
    tick();
    blk_req = 1'b0;
    t = 0;
    while (ndone == 0 && t < 60) begin
      tick();
      t++;
    end
    check("nopf_finish_beats", beats, 18);
    check("nopf_finish_done", ndone, 1);
`endif
    repeat (3) tick();
    check("pf_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
